spiflash_axi_prefetch: RTL and testbench

SPIFLASH_AXI_PREFETCH -- requirements
Module: spiflash_axi_prefetch

---
 rtl/spiflash_axi_pkg.sv | 14 +
 rtl/spiflash_pfbuf.sv | 58 +++++
 rtl/spiflash_axi_prefetch.sv | 225 ++++++++++++++++++++++
 tb/tb_spiflash_axi_prefetch.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spiflash_axi_pkg.sv
// Shared response codes and read-FSM encoding for the SPI-flash AXI-lite prefetch bridge.
package spiflash_axi_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FETCH    = 2'd1,
      RESP     = 2'd2,
      PREFETCH = 2'd3
   } rd_state_t;

endpackage

// File: rtl/spiflash_pfbuf.sv
// Sequential prefetch buffer: words base..base+count-1, filled at count, read by offset from base.
module spiflash_pfbuf #(
   parameter int unsigned WAW   = 22,
   parameter int unsigned DEPTH = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           clear,
   input  logic           load,
   input  logic [WAW-1:0] load_base,
   input  logic           wr_en,
   input  logic [31:0]    wr_data,
   input  logic [WAW-1:0] rd_addr,
   output logic           hit,
   output logic [31:0]    rd_data,
   output logic [WAW-1:0] next_addr,
   output logic           full,
   output logic           valid
);
   localparam int unsigned IW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [31:0]    mem [DEPTH];
   logic [WAW-1:0] base;
   logic [CW-1:0]  count;
   logic [WAW-1:0] offset;
   logic           do_wr;

   // Offset arithmetic is modulo the flash size, so a window may wrap past the top.
   assign offset    = rd_addr - base;
   assign hit       = valid && (offset < WAW'(count));
   assign rd_data   = mem[offset[IW-1:0]];
   assign next_addr = base + WAW'(count);
   assign full      = (count == CW'(DEPTH));
   assign do_wr     = wr_en && !full && !clear && !load;

   always_ff @(posedge clk) begin
      if (reset) begin
         base  <= '0;
         count <= '0;
         valid <= 1'b0;
      end else if (clear) begin
         count <= '0;
         valid <= 1'b0;
      end else if (load) begin
         base  <= load_base;
         count <= '0;
         valid <= 1'b1;
      end else if (do_wr) begin
         count <= count + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[count[IW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/spiflash_axi_prefetch.sv
// AXI-lite slave in front of a word-wide flash core with a sequential prefetch buffer
// and a single memory-mapped config register.
module spiflash_axi_prefetch
   import spiflash_axi_pkg::*;
#(
   parameter int unsigned FLASH_AW    = 24,
   parameter int unsigned DEPTH       = 4,
   parameter logic [31:0] CFG_ADDR    = 32'h0200_0000,
   parameter bit          PREFETCH_EN = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                awvalid,
   output logic                awready,
   input  logic [31:0]         awaddr,
   input  logic                wvalid,
   output logic                wready,
   input  logic [31:0]         wdata,
   input  logic [3:0]          wstrb,
   output logic                bvalid,
   input  logic                bready,
   output logic [1:0]          bresp,
   input  logic                arvalid,
   output logic                arready,
   input  logic [31:0]         araddr,
   output logic                rvalid,
   input  logic                rready,
   output logic [31:0]         rdata,
   output logic [1:0]          rresp,
   output logic                mem_valid,
   input  logic                mem_ready,
   output logic [FLASH_AW-1:0] mem_addr,
   input  logic [31:0]         mem_rdata,
   output logic [3:0]          cfg_we,
   output logic [31:0]         cfg_di,
   input  logic [31:0]         cfg_do
);
   localparam int unsigned WAW = FLASH_AW - 2;

   rd_state_t           state, state_n;
   logic                aw_full, aw_full_n, w_full, w_full_n, wr_go, wr_go_n;
   logic [31:0]         aw_addr_q, aw_addr_n, w_data_q, w_data_n;
   logic [3:0]          w_strb_q, w_strb_n;
   logic                arready_n, rvalid_n, awready_n, wready_n, bvalid_n, mem_valid_n;
   logic [31:0]         rdata_n, cfg_di_n;
   logic [1:0]          bresp_n;
   logic [3:0]          cfg_we_n;
   logic [FLASH_AW-1:0] mem_addr_n;
   logic                ar_hs, ar_cfg, wr_pend, wr_cfg, wr_issue, cfg_pend_n;
   logic                buf_clear, buf_load, buf_wr, buf_hit, buf_full, buf_valid;
   logic [WAW-1:0]      ar_word, buf_next;
   logic [31:0]         buf_rdata;

   assign ar_word  = araddr[FLASH_AW-1:2];
   assign ar_hs    = arvalid && arready;
   assign ar_cfg   = (araddr == CFG_ADDR);
   assign wr_pend  = aw_full && w_full && !wr_go && !bvalid;
   assign wr_cfg   = (aw_addr_q == CFG_ADDR);
   // Flash-region writes have no side effect and may complete at any time; config
   // writes must not race a flash access or a buffer update.
   assign wr_issue = wr_pend && (!wr_cfg || (state == IDLE && !mem_valid));

   spiflash_pfbuf #(.WAW(WAW), .DEPTH(DEPTH)) u_pfbuf (
      .clk       (clk),
      .reset     (reset),
      .clear     (buf_clear),
      .load      (buf_load),
      .load_base (ar_word),
      .wr_en     (buf_wr),
      .wr_data   (mem_rdata),
      .rd_addr   (ar_word),
      .hit       (buf_hit),
      .rd_data   (buf_rdata),
      .next_addr (buf_next),
      .full      (buf_full),
      .valid     (buf_valid)
   );

   always_comb begin
      state_n     = state;
      aw_full_n   = aw_full;
      w_full_n    = w_full;
      aw_addr_n   = aw_addr_q;
      w_data_n    = w_data_q;
      w_strb_n    = w_strb_q;
      wr_go_n     = 1'b0;
      rvalid_n    = rvalid;
      rdata_n     = rdata;
      bvalid_n    = bvalid;
      bresp_n     = bresp;
      mem_valid_n = mem_valid;
      mem_addr_n  = mem_addr;
      cfg_we_n    = '0;
      cfg_di_n    = cfg_di;
      buf_clear   = 1'b0;
      buf_load    = 1'b0;
      buf_wr      = 1'b0;

      if (awvalid && awready) begin
         aw_full_n = 1'b1;
         aw_addr_n = awaddr;
      end
      if (wvalid && wready) begin
         w_full_n = 1'b1;
         w_data_n = wdata;
         w_strb_n = wstrb;
      end
      if (wr_issue) begin
         wr_go_n = 1'b1;
         if (wr_cfg) begin
            cfg_we_n  = w_strb_q;
            cfg_di_n  = w_data_q;
            buf_clear = 1'b1;
         end
      end
      if (wr_go) begin
         bvalid_n = 1'b1;
         bresp_n  = wr_cfg ? RESP_OKAY : RESP_SLVERR;
      end
      if (bvalid && bready) begin
         bvalid_n  = 1'b0;
         aw_full_n = 1'b0;
         w_full_n  = 1'b0;
      end

      unique case (state)
         IDLE: begin
            if (ar_hs) begin
               if (ar_cfg) begin
                  rdata_n  = cfg_do;
                  rvalid_n = 1'b1;
                  state_n  = RESP;
               end else if (buf_hit) begin
                  rdata_n  = buf_rdata;
                  rvalid_n = 1'b1;
                  state_n  = RESP;
               end else begin
                  buf_load    = 1'b1;
                  mem_valid_n = 1'b1;
                  mem_addr_n  = {ar_word, 2'b00};
                  state_n     = FETCH;
               end
            end else if (!(wr_issue && wr_cfg) && PREFETCH_EN && buf_valid && !buf_full) begin
               mem_valid_n = 1'b1;
               mem_addr_n  = {buf_next, 2'b00};
               state_n     = PREFETCH;
            end
         end
         FETCH: begin
            if (mem_ready) begin
               buf_wr      = 1'b1;
               rdata_n     = mem_rdata;
               rvalid_n    = 1'b1;
               mem_valid_n = 1'b0;
               state_n     = RESP;
            end
         end
         RESP: begin
            if (rready) begin
               rvalid_n = 1'b0;
               state_n  = IDLE;
            end
         end
         PREFETCH: begin
            if (mem_ready) begin
               buf_wr      = 1'b1;
               mem_valid_n = 1'b0;
               state_n     = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase

      // A config write pending next cycle keeps AR blocked so it is issued first.
      cfg_pend_n = aw_full_n && w_full_n && !wr_go_n && !bvalid_n && (aw_addr_n == CFG_ADDR);
      arready_n  = (state_n == IDLE) && !cfg_pend_n;
      awready_n  = !aw_full_n;
      wready_n   = !w_full_n;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         aw_full   <= 1'b0;
         w_full    <= 1'b0;
         aw_addr_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         wr_go     <= 1'b0;
         arready   <= 1'b0;
         awready   <= 1'b0;
         wready    <= 1'b0;
         rvalid    <= 1'b0;
         rdata     <= '0;
         rresp     <= RESP_OKAY;
         bvalid    <= 1'b0;
         bresp     <= RESP_OKAY;
         mem_valid <= 1'b0;
         mem_addr  <= '0;
         cfg_we    <= '0;
         cfg_di    <= '0;
      end else begin
         state     <= state_n;
         aw_full   <= aw_full_n;
         w_full    <= w_full_n;
         aw_addr_q <= aw_addr_n;
         w_data_q  <= w_data_n;
         w_strb_q  <= w_strb_n;
         wr_go     <= wr_go_n;
         arready   <= arready_n;
         awready   <= awready_n;
         wready    <= wready_n;
         rvalid    <= rvalid_n;
         rdata     <= rdata_n;
         rresp     <= RESP_OKAY;
         bvalid    <= bvalid_n;
         bresp     <= bresp_n;
         mem_valid <= mem_valid_n;
         mem_addr  <= mem_addr_n;
         cfg_we    <= cfg_we_n;
         cfg_di    <= cfg_di_n;
      end
   end

endmodule

// File: tb/tb_spiflash_axi_prefetch.sv
// Scoreboard bench: stimulus pushes expected R/B/memory/config events, monitors pop and compare.
module tb_spiflash_axi_prefetch;
   localparam logic [31:0] CFG = 32'h0200_0000;
   localparam int          FLASH_LAT = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic [31:0] awaddr, wdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] araddr, rdata;
   logic [1:0]  rresp;
   logic        mem_valid, mem_ready;
   logic [23:0] mem_addr;
   logic [31:0] mem_rdata;
   logic [3:0]  cfg_we;
   logic [31:0] cfg_di, cfg_do;

   int n_vec = 0;
   int n_bad = 0;

   logic [31:0] exp_r   [$];
   logic [1:0]  exp_b   [$];
   logic [23:0] exp_mem [$];
   logic [35:0] exp_cfg [$];

   always #5 clk = ~clk;

   spiflash_axi_prefetch dut (
      .clk(clk), .reset(reset),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
      .bvalid(bvalid), .bready(bready), .bresp(bresp),
      .arvalid(arvalid), .arready(arready), .araddr(araddr),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .cfg_we(cfg_we), .cfg_di(cfg_di), .cfg_do(cfg_do)
   );

   task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tmo(input string name);
      n_vec++;
      n_bad++;
      $display("FAIL %s: timed out / missing event", name);
   endtask

   // Flash core model: ready after FLASH_LAT extra cycles, data derived from the address.
   initial begin
      int lat = 0;
      mem_ready = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk); #1;
         if (mem_ready) begin
            mem_ready = 1'b0;
            lat = 0;
         end else if (mem_valid && !reset) begin
            if (lat == FLASH_LAT) begin
               mem_ready = 1'b1;
               mem_rdata = 32'hF000_0000 | 32'(mem_addr);
               lat = 0;
            end else lat++;
         end else lat = 0;
      end
   end

   // Monitors
   always @(negedge clk) begin
      if (!reset && rvalid && rready) begin
         if (exp_r.size() == 0) tmo("unexpected_r");
         else chk("rdata", 36'(rdata), 36'(exp_r.pop_front()));
         chk("rresp", 36'(rresp), 36'(0));
      end
      if (!reset && bvalid && bready) begin
         if (exp_b.size() == 0) tmo("unexpected_b");
         else chk("bresp", 36'(bresp), 36'(exp_b.pop_front()));
      end
      if (!reset && mem_valid && mem_ready) begin
         if (exp_mem.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL unexpected_mem: got addr %h expected none", mem_addr);
         end else chk("mem_addr", 36'(mem_addr), 36'(exp_mem.pop_front()));
      end
      if (!reset && cfg_we != 4'b0) begin
         if (exp_cfg.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL unexpected_cfg_we: got %h expected 0", cfg_we);
         end else chk("cfg_we_di", {cfg_we, cfg_di}, exp_cfg.pop_front());
      end
   end

   // mem_valid/mem_addr must hold until mem_ready.
   always @(negedge clk) begin
      static logic        pv = 1'b0, pr = 1'b0, prst = 1'b1;
      static logic [23:0] pa = '0;
      if (pv && !pr && !prst) chk("mem_hold", {11'b0, mem_valid, mem_addr}, {11'b0, 1'b1, pa});
      pv = mem_valid; pr = mem_ready; pa = mem_addr; prst = reset;
   end

   task automatic rd(input logic [31:0] a, input logic [31:0] e, input int hold, output int lat);
      int n = 0;
      exp_r.push_back(e);
      arvalid = 1'b1; araddr = a; rready = (hold == 0);
      @(negedge clk);
      while (!arready && n < 200) begin @(negedge clk); n++; end
      if (!arready) begin tmo("ar_handshake"); arvalid = 1'b0; void'(exp_r.pop_back()); lat = -1; return; end
      @(posedge clk); #1 arvalid = 1'b0;
      lat = 1;
      @(negedge clk);
      while (!rvalid && lat < 200) begin @(negedge clk); lat++; end
      if (!rvalid) begin tmo("rvalid_wait"); rready = 1'b1; return; end
      for (int i = 0; i < hold; i++) begin
         chk("rdata_stable", 36'(rdata), 36'(e));
         @(posedge clk); #1;
         if (i == hold - 1) rready = 1'b1;
         @(negedge clk);
      end
      @(posedge clk); #1;
   endtask

   task automatic send_aw(input logic [31:0] a);
      int n = 0;
      awvalid = 1'b1; awaddr = a;
      @(negedge clk);
      while (!awready && n < 200) begin @(negedge clk); n++; end
      if (!awready) tmo("aw_handshake");
      @(posedge clk); #1 awvalid = 1'b0;
   endtask

   task automatic send_w(input logic [31:0] d, input logic [3:0] s);
      int n = 0;
      wvalid = 1'b1; wdata = d; wstrb = s;
      @(negedge clk);
      while (!wready && n < 200) begin @(negedge clk); n++; end
      if (!wready) tmo("w_handshake");
      @(posedge clk); #1 wvalid = 1'b0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     input int w_lead, input logic [1:0] er);
      int n = 0;
      exp_b.push_back(er);
      if (a == CFG) exp_cfg.push_back({s, d});
      if (w_lead > 0) begin
         send_w(d, s); repeat (w_lead) @(posedge clk); #1; send_aw(a);
      end else if (w_lead < 0) begin
         send_aw(a); repeat (-w_lead) @(posedge clk); #1; send_w(d, s);
      end else fork send_aw(a); send_w(d, s); join
      @(negedge clk);
      while (!bvalid && n < 200) begin @(negedge clk); n++; end
      if (!bvalid) tmo("bvalid_wait");
      @(posedge clk); #1;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_mem.size() != 0 && n < 300) begin @(posedge clk); n++; end
      if (exp_mem.size() != 0) begin tmo("mem_drain"); exp_mem.delete(); end
      repeat (4) @(posedge clk); #1;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat, lat2, n;
      reset = 1'b1; awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
      awaddr = '0; wdata = '0; wstrb = '0; araddr = '0; cfg_do = 32'hC0DE_0001;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_arready", 36'(arready), 36'(0));
      chk("rst_awready", 36'(awready), 36'(0));
      chk("rst_wready", 36'(wready), 36'(0));
      chk("rst_rvalid", 36'(rvalid), 36'(0));
      chk("rst_bvalid", 36'(bvalid), 36'(0));
      chk("rst_mem_valid", 36'(mem_valid), 36'(0));
      chk("rst_cfg_we", 36'(cfg_we), 36'(0));
      chk("rst_resp", {32'b0, bresp, rresp}, 36'(0));
      chk("rst_rdata", 36'(rdata), 36'(0));
      chk("rst_mem_addr", 36'(mem_addr), 36'(0));
      @(posedge clk); #1 reset = 1'b0;
      repeat (2) @(posedge clk); #1;

      // Miss at 0x100, then three prefetches; hits afterwards
      exp_mem.push_back(24'h000100); exp_mem.push_back(24'h000104);
      exp_mem.push_back(24'h000108); exp_mem.push_back(24'h00010C);
      rd(32'h0000_0100, 32'hF000_0100, 0, lat);
      drain();
      rd(32'h0000_0104, 32'hF000_0104, 0, lat);
      chk("hit_lat_104", 36'(lat), 36'(1));
      rd(32'h0000_010F, 32'hF000_010C, 0, lat);
      chk("hit_lat_10f", 36'(lat), 36'(1));
      rd(32'h1000_0108, 32'hF000_0108, 0, lat);
      chk("hit_lat_upper", 36'(lat), 36'(1));
      chk("full_no_mem", 36'(mem_valid), 36'(0));

      // Miss at 0x200 flushes the buffer
      exp_mem.push_back(24'h000200); exp_mem.push_back(24'h000204);
      exp_mem.push_back(24'h000208); exp_mem.push_back(24'h00020C);
      rd(32'h0000_0200, 32'hF000_0200, 0, lat);
      chk("miss_200", 36'(lat > 1), 36'(1));
      drain();

      // Refill at 0x100, config write invalidates, 0x104 then misses
      exp_mem.push_back(24'h000100); exp_mem.push_back(24'h000104);
      exp_mem.push_back(24'h000108); exp_mem.push_back(24'h00010C);
      rd(32'h0000_0100, 32'hF000_0100, 0, lat);
      drain();
      wr(CFG, 32'h8000_0000, 4'b1000, 3, 2'b00);
      repeat (3) @(posedge clk); #1;
      chk("cfg_no_prefetch", 36'(mem_valid), 36'(0));
      exp_mem.push_back(24'h000104); exp_mem.push_back(24'h000108);
      exp_mem.push_back(24'h00010C); exp_mem.push_back(24'h000110);
      rd(32'h0000_0104, 32'hF000_0104, 0, lat);
      chk("miss_after_cfg", 36'(lat > 1), 36'(1));
      drain();

      // Flash-region write: SLVERR, no side effects
      wr(32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, -2, 2'b10);
      chk("slverr_no_mem", 36'(mem_valid), 36'(0));

      // Config read returns cfg_do
      rd(CFG, 32'hC0DE_0001, 0, lat);
      cfg_do = 32'h5A5A_0F0F;
      rd(CFG, 32'h5A5A_0F0F, 0, lat);

      // Wrap past top of flash with rready held low
      exp_mem.push_back(24'hFFFFFC); exp_mem.push_back(24'h000000);
      exp_mem.push_back(24'h000004); exp_mem.push_back(24'h000008);
      rd(32'h00FF_FFFC, 32'hF0FF_FFFC, 5, lat);
      drain();
      rd(32'h0000_0004, 32'hF000_0004, 0, lat);
      chk("hit_lat_wrap", 36'(lat), 36'(1));

      // Config write and AR pending together
      fork
         wr(CFG, 32'h0000_00A5, 4'b0001, 0, 2'b00);
         begin @(posedge clk); #1; rd(CFG, 32'h5A5A_0F0F, 0, lat2); end
      join
      repeat (3) @(posedge clk); #1;

      // Reset during FETCH
      n = 0;
      arvalid = 1'b1; araddr = 32'h0000_0300;
      @(negedge clk);
      while (!arready && n < 200) begin @(negedge clk); n++; end
      if (!arready) tmo("ar_reset_case");
      @(posedge clk); #1 arvalid = 1'b0;
      n = 0;
      @(negedge clk);
      while (!mem_valid && n < 50) begin @(negedge clk); n++; end
      if (!mem_valid) tmo("fetch_start");
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rst_fetch_mem_valid", 36'(mem_valid), 36'(0));
      chk("rst_fetch_rvalid", 36'(rvalid), 36'(0));
      @(posedge clk); #1 reset = 1'b0;
      repeat (2) @(posedge clk); #1;
      exp_mem.push_back(24'h000300); exp_mem.push_back(24'h000304);
      exp_mem.push_back(24'h000308); exp_mem.push_back(24'h00030C);
      rd(32'h0000_0300, 32'hF000_0300, 0, lat);
      drain();

      repeat (5) @(posedge clk);
      if (exp_r.size() != 0) tmo("leftover_r");
      if (exp_b.size() != 0) tmo("leftover_b");
      if (exp_mem.size() != 0) tmo("leftover_mem");
      if (exp_cfg.size() != 0) tmo("leftover_cfg");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
